// File: rtl/fir_serial_mac.sv
// Serial FIR: one sample per sample_en strobe, TAPS multiply-accumulate cycles on a shared multiplier.
// Define FIR_SAT_EN to clamp the output to the signed DATA_W range; otherwise the output wraps.
module fir_serial_mac #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 8,
  parameter int ACC_W     = 35,
  parameter int OUT_SHIFT = 15
) (
  input  logic                      clk_in,
  input  logic                      rst,
  input  logic                      sample_en,
  input  logic signed [DATA_W-1:0]  din,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]  coef_data,
  output logic signed [DATA_W-1:0]  dout,
  output logic                      dout_valid,
  output logic                      busy,
  output logic                      overrun,
  input  logic                      ovr_clr
);

  // state | meaning
  // IDLE  | waiting for sample_en; coefficient writes accepted
  // MAC   | one multiply-accumulate per cycle, tap k = 0..TAPS-1
  // DONE  | accumulator complete; load dout and pulse dout_valid

  localparam int AW = $clog2(TAPS);
  localparam int PW = DATA_W + COEF_W;
  localparam logic [AW-1:0] LAST   = AW'(TAPS - 1);
  localparam logic [AW:0]   TAPS_C = (AW + 1)'(TAPS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic signed [DATA_W-1:0] x_mem    [TAPS];
  logic signed [COEF_W-1:0] coef_mem [TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic [AW-1:0]            wr_ptr, rd_ptr, k;

  logic                     capture, mac_step, finish, drop, coef_wr;
  logic signed [PW-1:0]     prod;
  logic [ACC_W-1:0]         prod_ext;
  logic [DATA_W-1:0]        out_val;

  always_ff @(posedge clk_in) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    mac_step  = 1'b0;
    finish    = 1'b0;
    drop      = 1'b0;
    case (state)
      S_IDLE: begin
        if (sample_en) begin
          capture   = 1'b1;
          state_nxt = S_MAC;
        end
      end
      S_MAC: begin
        mac_step = 1'b1;
        drop     = sample_en;
        if (k == LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        finish    = 1'b1;
        drop      = sample_en;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign coef_wr  = coef_we && (state == S_IDLE) && ({1'b0, coef_addr} < TAPS_C);
  assign prod     = x_mem[rd_ptr] * coef_mem[k];
  assign prod_ext = {{(ACC_W - PW){prod[PW-1]}}, prod};

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};
  logic signed [ACC_W-1:0] shifted;

  assign shifted = acc >>> OUT_SHIFT;

  always_comb begin
    out_val = shifted[DATA_W-1:0];
    if (shifted > SAT_MAX)      out_val = SAT_MAX[DATA_W-1:0];
    else if (shifted < SAT_MIN) out_val = SAT_MIN[DATA_W-1:0];
  end
`else
  // Low DATA_W bits of acc >>> OUT_SHIFT; wraps when out of range.
  assign out_val = acc[OUT_SHIFT +: DATA_W];
`endif

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) begin
        x_mem[i]    <= '0;
        coef_mem[i] <= '0;
      end
      acc        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      k          <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      busy       <= (state_nxt != S_IDLE);

      if (coef_wr) coef_mem[coef_addr] <= coef_data;

      if (capture) begin
        x_mem[wr_ptr] <= din;
        rd_ptr        <= wr_ptr;
        wr_ptr        <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
        acc           <= '0;
        k             <= '0;
      end

      if (mac_step) begin
        acc    <= acc + prod_ext;
        rd_ptr <= (rd_ptr == '0) ? LAST : rd_ptr - 1'b1;
        k      <= k + 1'b1;
      end

      if (finish) begin
        dout       <= out_val;
        dout_valid <= 1'b1;
      end

      // A drop in the same cycle as ovr_clr keeps the flag set.
      if (drop)         overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: doc/fir_serial_mac.md
Name: fir_serial_mac

Overview:
- Strobe-driven serial FIR filter that sits directly downstream of the sample-rate divider.
- Each clk_en pulse from the divider, wired to sample_en, captures one input sample into a circular delay line.
- The block then runs TAPS multiply-accumulate cycles on one shared multiplier and presents one filtered sample with a single-cycle valid pulse.
- Coefficients are loaded through a simple write port.

Parameters:
- DATA_W, 16: signed input and output sample width.
- COEF_W, 16: signed coefficient width.
- TAPS, 8: filter length; also the delay-line depth (must be ≥2).
- ACC_W, 35: accumulator width, equal to DATA_W+COEF_W+clog2(TAPS).
- OUT_SHIFT, 15: arithmetic right shift applied to the accumulator before output (Q15 coefficients).

Ports:
- clk_in  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-low reset.
- sample_en  in  1  one-cycle sample strobe, driven by the divider's clk_en.
- din  in  DATA_W  signed input sample, valid when sample_en=1.
- coef_we  in  1  coefficient write enable.
- coef_addr  in  clog2(TAPS)  coefficient index k.
- coef_data  in  COEF_W  signed coefficient value.
- dout  out  DATA_W  signed filtered sample.
- dout_valid  out  1  one-cycle pulse when dout updates.
- busy  out  1  high while a MAC sequence is in progress.
- overrun  out  1  sticky flag: a sample was dropped.
- ovr_clr  in  1  clears overrun.

Behaviour:
- Reset (rst=0 at a clk_in edge):
  - State goes to IDLE.
  - Delay line, coefficients, accumulator, pointers, dout, dout_valid, busy and overrun all clear to 0.
  - Reset overrides every other input.
- Filter equation: y[n] = sum over k=0..TAPS-1 of c[k]*x[n-k], signed two's complement. Products are DATA_W+COEF_W bits, sign-extended into ACC_W.
- State machine: IDLE -> MAC -> DONE -> IDLE.
  - IDLE, edge E0 with sample_en=1: din is written at wr_ptr; rd_ptr is set to wr_ptr; wr_ptr advances (TAPS-1 wraps to 0); accumulator clears; tap index goes to 0; busy=1; go to MAC.
  - MAC, edges E1..E_TAPS: acc += c[k]*x[rd_ptr]; rd_ptr decrements (0 wraps to TAPS-1); k increments. After k=TAPS-1, go to DONE.
  - DONE, edge E_TAPS+1: dout is loaded from the output stage; dout_valid=1 for exactly one cycle; busy=0; go to IDLE.
- Latency and throughput:
  - dout_valid is high in the cycle following edge E_TAPS+1, i.e. TAPS+1 edges after capture.
  - dout holds its value until the next DONE.
  - A new sample_en can be accepted on the edge after dout_valid rises.
  - Minimum strobe period is TAPS+2 clocks.
- Output stage: s = acc >>> OUT_SHIFT (arithmetic). Without saturation, dout = s[DATA_W-1:0], so out-of-range values wrap.
- sample_en in MAC or DONE: the sample is dropped, the delay line is untouched, and overrun is set. The current result is unaffected.
- Overrun flag:
  - overrun stays high until ovr_clr=1.
  - If a set and ovr_clr occur in the same cycle, set wins.
- Coefficient writes:
  - coef_we in IDLE writes coef_data to c[coef_addr] on that edge. The new value applies to the next capture.
  - coef_we while busy=1, or with coef_addr ≥ TAPS, is ignored.
  - If coef_we and sample_en occur in the same IDLE cycle, both are performed.
- Reset mid-sequence: the sequence aborts with no dout_valid; dout returns to 0.

Optional Feature:
- Macro FIR_SAT_EN.
- Defined: if s > 2^(DATA_W-1)-1, dout = 2^(DATA_W-1)-1. If s < -2^(DATA_W-1), dout = -2^(DATA_W-1). Otherwise dout = s.
- Undefined: plain truncation with wrap, as described under Output stage. No saturation logic is present.

Test Plan:
1. Reset: hold rst=0 for 3 clocks with random inputs -> dout=0, dout_valid=0, busy=0, overrun=0; first filtered output after reset is 0 for din=0.
2. Impulse response (defaults):
   - Stimulus: load c[k]=2048*(k+1) for k=0..7; strobe every 20 clocks with din=16384 once, then 0 for 9 strobes.
   - Required: dout = 1024, 2048, 3072, 4096, 5120, 6144, 7168, 8192, then 0. The final 0 checks pointer wrap.
3. Latency and busy:
   - Stimulus: sample_en accepted at edge E0.
   - Required: busy is high for the cycles after E0 through E8; dout_valid is high only in the cycle after E9; busy=0 in that cycle.
4. Overrun:
   - Stimulus: a second sample_en 3 clocks after an accepted one.
   - Required: overrun=1; the first result is unchanged; the dropped sample never appears in later outputs.
   - Stimulus: ovr_clr=1 -> overrun=0 next cycle. Stimulus: ovr_clr and a drop in the same cycle -> overrun stays 1.
5. Overflow:
   - Stimulus: all c[k]=32767; 8 strobes with din=32767.
   - Required without FIR_SAT_EN: dout = -16 (0xFFF0). Required with FIR_SAT_EN: dout = 32767.
6. Mid-sequence and coefficient rules:
   - Stimulus: rst=0 on edge E4 of a MAC sequence -> no dout_valid; busy=0; dout=0.
   - Stimulus: coef_we during busy -> coefficient unchanged, verified by the next impulse response.
